// File: rtl/ex_mdu_unit_pkg.sv
// Shared definitions for the execute-stage multiply/divide unit:
// function-field op codes, FSM state encoding and the divide-by-zero LO fill.
package ex_mdu_unit_pkg;

  localparam logic [5:0] OP_MFHI  = 6'h10;
  localparam logic [5:0] OP_MTHI  = 6'h11;
  localparam logic [5:0] OP_MFLO  = 6'h12;
  localparam logic [5:0] OP_MTLO  = 6'h13;
  localparam logic [5:0] OP_MULT  = 6'h18;
  localparam logic [5:0] OP_MULTU = 6'h19;
  localparam logic [5:0] OP_DIV   = 6'h1A;
  localparam logic [5:0] OP_DIVU  = 6'h1B;

  // LO after a divide by zero is all ones at any operand width
  localparam logic DIV0_LO_FILL = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } mdu_state_t;

  function automatic logic is_muldiv(input logic [5:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/ex_mdu_datapath.sv
// Radix-2 multiply/divide datapath: 2*WIDTH accumulator shift register,
// add/subtract step and the final sign-correction negators.
module ex_mdu_datapath #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             load,
  input  logic             step,
  input  logic             op_div,
  input  logic             op_signed,
  input  logic             neg_main,
  input  logic             neg_rem,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);

  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v,
                                                 input logic is_signed);
    return (is_signed && v < 0) ? -v : v;
  endfunction

  logic [2*WIDTH-1:0] acc_p0, acc_next, prod_fix;
  logic [WIDTH-1:0]   dvsr_p0, rs_mag, rt_mag, trial;
  logic [WIDTH:0]     sum, part;
  logic               mode_div_p0;

  assign rs_mag = magnitude(rs, op_signed);
  assign rt_mag = magnitude(rt, op_signed);

  // Multiply: add multiplicand into the upper half when the multiplier LSB is set,
  // then shift right. Divide: shift the remainder left and keep the difference
  // when it does not borrow; a zero divisor therefore yields an all-ones quotient.
  always_comb begin
    sum      = {1'b0, acc_p0[2*WIDTH-1:WIDTH]} + {1'b0, dvsr_p0};
    part     = {acc_p0[2*WIDTH-1:WIDTH], acc_p0[WIDTH-1]};
    trial    = part[WIDTH-1:0] - dvsr_p0;
    acc_next = '0;
    if (mode_div_p0) begin
      if (part >= {1'b0, dvsr_p0}) acc_next = {trial, acc_p0[WIDTH-2:0], 1'b1};
      else                         acc_next = {acc_p0[2*WIDTH-2:0], 1'b0};
    end else begin
      if (acc_p0[0]) acc_next = {sum, acc_p0[WIDTH-1:1]};
      else           acc_next = {1'b0, acc_p0[2*WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      acc_p0      <= {{WIDTH{1'b0}}, (op_div ? rs_mag : rt_mag)};
      dvsr_p0     <= op_div ? rt_mag : rs_mag;
      mode_div_p0 <= op_div;
    end else if (step) begin
      acc_p0      <= acc_next;
    end
  end

  assign prod_fix = neg_main ? -acc_p0 : acc_p0;

  always_comb begin
    if (mode_div_p0) begin
      res_hi = neg_rem  ? -acc_p0[2*WIDTH-1:WIDTH] : acc_p0[2*WIDTH-1:WIDTH];
      res_lo = neg_main ? -acc_p0[WIDTH-1:0]       : acc_p0[WIDTH-1:0];
    end else begin
      res_hi = prod_fix[2*WIDTH-1:WIDTH];
      res_lo = prod_fix[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/ex_mdu_unit.sv
// Execute-stage MIPS multiply/divide unit: owns HI/LO, sequences the iterative
// datapath, services MF/MT ops and interlocks the upstream pipeline.
module ex_mdu_unit
  import ex_mdu_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_i,
  input  logic [5:0]       alu_op_i,
  input  logic [WIDTH-1:0] rs_data_i,
  input  logic [WIDTH-1:0] rt_data_i,
  input  logic             kill_i,
  output logic             stall_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic [WIDTH-1:0] mf_data_o
);

  localparam int CNT_W = $clog2(WIDTH);

  mdu_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic             neg_main, neg_rem, div0;
  logic             idle, accept, op_div, op_signed, step;
  logic [WIDTH-1:0] res_hi, res_lo;

  assign idle      = (state == ST_IDLE);
  assign accept    = valid_i & is_muldiv(alu_op_i) & idle & ~kill_i;
  assign op_div    = (alu_op_i == OP_DIV) || (alu_op_i == OP_DIVU);
  assign op_signed = (alu_op_i == OP_MULT) || (alu_op_i == OP_DIV);
  assign step      = (state == ST_MUL) || (state == ST_DIV);

  // Busy covers the MF/MT/MUL/DIV interlock; an issuing MUL/DIV also holds
  // its own slot for the accept cycle.
  assign stall_o = ~idle | (valid_i & is_muldiv(alu_op_i));

  always_comb begin
    mf_data_o = '0;
    if (idle && alu_op_i == OP_MFHI) mf_data_o = hi_o;
    if (idle && alu_op_i == OP_MFLO) mf_data_o = lo_o;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      hi_o     <= '0;
      lo_o     <= '0;
      done_o   <= 1'b0;
      neg_main <= 1'b0;
      neg_rem  <= 1'b0;
      div0     <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state    <= op_div ? ST_DIV : ST_MUL;
            cnt      <= CNT_W'(WIDTH - 1);
            neg_main <= op_signed & (rs_data_i[WIDTH-1] ^ rt_data_i[WIDTH-1]);
            neg_rem  <= op_signed & op_div & rs_data_i[WIDTH-1];
            div0     <= op_div & (rt_data_i == '0);
          end else if (valid_i && !kill_i) begin
            if (alu_op_i == OP_MTHI) hi_o <= rs_data_i;
            if (alu_op_i == OP_MTLO) lo_o <= rs_data_i;
          end
        end
        ST_MUL, ST_DIV: begin
          if (kill_i)          state <= ST_IDLE;
          else if (cnt == '0)  state <= ST_FIX;
          else                 cnt   <= cnt - 1'b1;
        end
        ST_FIX: begin
          state <= ST_IDLE;
          if (!kill_i) begin
            hi_o   <= res_hi;
            lo_o   <= div0 ? {WIDTH{DIV0_LO_FILL}} : res_lo;
            done_o <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  ex_mdu_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk       (clk),
    .load      (accept),
    .step      (step),
    .op_div    (op_div),
    .op_signed (op_signed),
    .neg_main  (neg_main),
    .neg_rem   (neg_rem),
    .rs        (rs_data_i),
    .rt        (rt_data_i),
    .res_hi    (res_hi),
    .res_lo    (res_lo)
  );

endmodule

// File: doc/ex_mdu_unit.md
Name: ex_mdu_unit

Overview:
- Execute-stage consumer of the issue-execute pipeline register's decoded fields (valid, alu_op, rs/rt read data).
- Implements MIPS multiply/divide (MULT, MULTU, DIV, DIVU) as an iterative radix-2 engine that owns the architectural HI/LO registers.
- Services MFHI/MFLO/MTHI/MTLO.
- Raises stall_o back to the hazard logic so the issue-execute register and the earlier stages hold while an operation is in flight.

Parameters:
- WIDTH, 32, operand/HI/LO width; iteration count equals WIDTH.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- valid_i  in  1  execute-stage instruction valid
- alu_op_i  in  6  decoded ALU op (function-field encoding)
- rs_data_i  in  WIDTH  forwarded rs operand (dividend / multiplicand / MT source)
- rt_data_i  in  WIDTH  forwarded rt operand (divisor / multiplier)
- kill_i  in  1  flush from branch mispredict; aborts the in-flight op
- stall_o  out  1  hold upstream pipeline
- done_o  out  1  one-cycle pulse when HI/LO are written by a MULT/DIV
- hi_o  out  WIDTH  architectural HI
- lo_o  out  WIDTH  architectural LO
- mf_data_o  out  WIDTH  MFHI/MFLO result to the execute result mux

Behaviour:
- Reset (async): state IDLE, counter 0, hi_o = lo_o = 0, stall_o = 0, done_o = 0, mf_data_o = 0.
- Op codes (package constants): MFHI 0x10, MTHI 0x11, MFLO 0x12, MTLO 0x13, MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B. All other codes are ignored.
- Accept condition: valid_i & MULT/MULTU/DIV/DIVU & state IDLE & !kill_i.
  - On the accepting edge, latch operand magnitudes (absolute values for signed ops), result-sign flags, and op type.
  - Counter loads WIDTH-1.
- FSM:
  - IDLE -> MUL or DIV on accept.
  - MUL: shift-add, one multiplier bit per cycle. After the counter reaches 0, go to FIX.
  - DIV: restoring shift-subtract, one quotient bit per cycle. After the counter reaches 0, go to FIX.
  - FIX: apply sign correction, write HI/LO, pulse done_o, return to IDLE.
- Latency: accept at edge E0; HI/LO updated at edge E0+WIDTH+1 (33 for WIDTH=32). done_o is high in the cycle following that edge.
- stall_o (combinational):
  - Asserted when state != IDLE.
  - Also asserted when state == IDLE and valid_i carries MULT/MULTU/DIV/DIVU in the accept cycle, so the issuing instruction holds until acceptance completes.
  - Also asserted when valid_i carries MF*/MT*/MULT*/DIV* while state != IDLE (interlock).
  - stall_o is low in the cycle done_o is high.
- MULT: {HI,LO} = signed 64-bit product. MULTU: unsigned product.
- DIV: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - -2^31 / -1 yields LO = 0x80000000, HI = 0 (natural result of magnitude arithmetic).
  - DIVU is unsigned.
- Divide by zero (both signednesses): HI = rs_data, LO = 0xFFFFFFFF. Takes the full latency; no trap.
- MTHI/MTLO: when valid_i & state IDLE, HI or LO is written with rs_data_i on the next edge, single cycle, no stall.
- MFHI/MFLO: mf_data_o = hi_o or lo_o combinationally when state IDLE. Otherwise stall_o holds the instruction. mf_data_o = 0 for other ops.
- kill_i:
  - In any busy state: return to IDLE next edge; HI/LO unchanged; no done_o.
  - Concurrent with an accept candidate: no accept.
  - Concurrent with MTHI/MTLO: no write.
  - kill_i in the FIX cycle also suppresses the write.
- Back-to-back: a new MULT/DIV presented in the done_o cycle is accepted that cycle.

Decomposition:
- Shared package (e.g. mips_pkg):
  - Op-code constants above.
  - FSM state encoding (IDLE, MUL, DIV, FIX).
  - Divide-by-zero LO constant.
- Natural sub-module: ex_mdu_datapath. It holds the 2*WIDTH accumulator/remainder shift register, the adder/subtractor, and the sign-fix negators. The parent keeps the FSM, counter, stall/kill logic, and HI/LO registers.

Test Plan:
- MULT rs=0xFFFFFFFD (-3), rt=7 -> after 33 cycles HI=0xFFFFFFFF, LO=0xFFFFFFEB; done_o one pulse; stall_o high throughout.
- MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- DIV rs=-7 (0xFFFFFFF9), rt=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU rs=0x1234, rt=0 -> HI=0x1234, LO=0xFFFFFFFF after full latency.
- MFLO issued 1 cycle after a MULT is accepted -> stall_o held until done_o; then mf_data_o equals the new LO. MTHI 0xCAFEF00D while IDLE -> hi_o=0xCAFEF00D next cycle.
- DIV started, kill_i at cycle 10 -> IDLE next edge, HI/LO keep prior values, no done_o. Async reset at cycle 5 of a MULT -> all outputs 0 immediately.
